lcd_bus_ctl: RTL

- Downstream consumer of the LSU's io_lcd_o peripheral register.
- Turns software writes of that register into HD44780-compatible write cycles on the board LCD bus: setup, enable pulse, hold, then an execution wait.
- Software launches a transaction by toggling a strobe bit. It polls busy_o, which is wired back to an input-peripheral address.
- Write-only: RW is never driven high and the LCD busy flag is never read; fixed execution delays are used instead.

---
 rtl/lcd_bus_ctl_if.sv | 31 +++
 rtl/lcd_bus_ctl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/lcd_bus_ctl_if.sv
// rtl/lcd_bus_ctl_if.sv - register-side and LCD-side signal bundle for lcd_bus_ctl
//
// Purpose: groups the peripheral register input and the LCD bus outputs of lcd_bus_ctl.
// Signals:
//   lcd_reg_i  [10:0] LSU io_lcd_o[10:0]: [7:0] data, [8] RS, [9] power on, [10] strobe toggle
//   lcd_data_o [7:0]  LCD data bus
//   lcd_rs_o          LCD register select
//   lcd_rw_o          LCD read/write (always 0)
//   lcd_en_o          LCD enable
//   lcd_on_o          LCD power/backlight
//   busy_o            transaction in progress
// Modports: master = register/LCD side (drives lcd_reg_i), slave = controller.
interface lcd_bus_ctl_if;
  logic [10:0] lcd_reg_i;
  logic [7:0]  lcd_data_o;
  logic        lcd_rs_o;
  logic        lcd_rw_o;
  logic        lcd_en_o;
  logic        lcd_on_o;
  logic        busy_o;

  modport master (
    output lcd_reg_i,
    input  lcd_data_o, lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_on_o, busy_o
  );

  modport slave (
    input  lcd_reg_i,
    output lcd_data_o, lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_on_o, busy_o
  );
endinterface

// File: rtl/lcd_bus_ctl.sv
// rtl/lcd_bus_ctl.sv - HD44780-style write-cycle generator driven by a toggle-strobe register
//
// Purpose: turns software writes of the LCD peripheral register into LCD bus write
// cycles (setup, enable pulse, hold, execution wait). Write-only; the LCD busy flag
// is never read, fixed waits are used instead.
// Ports:
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset
//   bus     lcd_bus_ctl_if.slave (lcd_reg_i in; lcd_data_o, lcd_rs_o, lcd_rw_o,
//           lcd_en_o, lcd_on_o, busy_o out, all registered)
module lcd_bus_ctl #(
  parameter int unsigned SETUP_CYC = 3,
  parameter int unsigned PULSE_CYC = 25,
  parameter int unsigned HOLD_CYC  = 3,
  parameter int unsigned EXEC_CYC  = 2000,
  parameter int unsigned SLOW_CYC  = 82000,
  parameter int unsigned CW        = 17
) (
  input logic          clk_i,
  input logic          rst_ni,
  lcd_bus_ctl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    EXEC  = 3'd4
  } state_e;

  // Counter reload values: a phase of N cycles counts N-1 down to 0.
  localparam logic [CW-1:0] SETUP_LOAD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] EXEC_LOAD  = CW'(EXEC_CYC - 1);
  localparam logic [CW-1:0] SLOW_LOAD  = CW'(SLOW_CYC - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_tgl_q, last_tgl_d;
  logic [7:0]    data_q, data_d;
  logic          rs_q, rs_d;
  logic          en_q, en_d;
  logic          busy_q, busy_d;
  logic          on_q, on_d;

  logic          cnt_zero;
  logic          slow_cmd;

  assign cnt_zero = (cnt_q == '0);
  // Clear display (0x01) and return home (0x02) need the long execution wait.
  assign slow_cmd = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_tgl_d = last_tgl_q;
    data_d     = data_q;
    rs_d       = rs_q;

    case (state_q)
      IDLE: begin
        // A toggle that arrived while busy is still pending here and is taken now,
        // with data sampled at this edge rather than at toggle time.
        if (bus.lcd_reg_i[10] != last_tgl_q) begin
          state_d    = SETUP;
          cnt_d      = SETUP_LOAD;
          data_d     = bus.lcd_reg_i[7:0];
          rs_d       = bus.lcd_reg_i[8];
          last_tgl_d = bus.lcd_reg_i[10];
        end
      end
      SETUP: begin
        if (cnt_zero) begin
          state_d = PULSE;
          cnt_d   = PULSE_LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      PULSE: begin
        if (cnt_zero) begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      HOLD: begin
        if (cnt_zero) begin
          state_d = EXEC;
          cnt_d   = slow_cmd ? SLOW_LOAD : EXEC_LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      EXEC: begin
        if (cnt_zero) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    en_d   = (state_d == PULSE);
    busy_d = (state_d != IDLE);
    on_d   = bus.lcd_reg_i[9];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_tgl_q <= 1'b0;
      data_q     <= 8'h00;
      rs_q       <= 1'b0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      on_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_tgl_q <= last_tgl_d;
      data_q     <= data_d;
      rs_q       <= rs_d;
      en_q       <= en_d;
      busy_q     <= busy_d;
      on_q       <= on_d;
    end
  end

  assign bus.lcd_data_o = data_q;
  assign bus.lcd_rs_o   = rs_q;
  assign bus.lcd_rw_o   = 1'b0;
  assign bus.lcd_en_o   = en_q;
  assign bus.lcd_on_o   = on_q;
  assign bus.busy_o     = busy_q;

endmodule
